// File: rtl/pc_flow_ctrl.sv
// Fetch-path control sequencer: resolves JMP / JZ / HLT in decode and drives
// the PC mux, jump target, PC and program-memory stalls and the flush strobe.
module pc_flow_ctrl #(
  parameter logic [4:0]  OPC_JMP      = 5'b11000,
  parameter logic [4:0]  OPC_JZ       = 5'b11100,
  parameter logic [4:0]  OPC_HLT      = 5'b11111,
  parameter int unsigned FLAG_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic        zero_flag,
  input  logic        flag_valid,
  input  logic        ext_stall,
  input  logic        resume,
  output logic        pc_mux_sel,
  output logic [7:0]  jmp_loc,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic        halted,
  output logic        timeout_err,
  output logic [7:0]  jump_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(FLAG_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  target_q, target_d;
  logic        pc_mux_sel_q, pc_mux_sel_d;
  logic [7:0]  jmp_loc_q, jmp_loc_d;
  logic        stall_q, stall_d;
  logic        stall_pm_q, stall_pm_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  jump_count_q, jump_count_d;

  logic [4:0]  opcode;
  logic        unused_ins;

  assign opcode     = ins[19:15];
  assign unused_ins = ^ins[14:8];

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    target_d      = target_q;
    pc_mux_sel_d  = 1'b1;
    jmp_loc_d     = jmp_loc_q;
    stall_d       = 1'b0;
    stall_pm_d    = 1'b0;
    flush_d       = 1'b0;
    halted_d      = 1'b0;
    timeout_err_d = 1'b0;
    jump_count_d  = jump_count_q;

    if (ext_stall) begin
      // Everything freezes; the halt indication is held rather than dropped.
      stall_d  = 1'b1;
      halted_d = halted_q;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (opcode == OPC_JMP) begin
            state_d      = S_FLUSH;
            pc_mux_sel_d = 1'b0;
            jmp_loc_d    = ins[7:0];
            flush_d      = 1'b1;
            jump_count_d = jump_count_q + 8'd1;
          end else if (opcode == OPC_JZ) begin
            state_d    = S_WAIT;
            stall_d    = 1'b1;
            target_d   = ins[7:0];
            wait_cnt_d = 4'd0;
          end else if (opcode == OPC_HLT) begin
            state_d  = S_HALT;
            stall_d  = 1'b1;
            halted_d = 1'b1;
          end
        end
        S_FLUSH: begin
          state_d = S_RUN;
        end
        S_WAIT: begin
          // A valid flag beats the timeout when both land on the same cycle.
          if (flag_valid) begin
            if (zero_flag) begin
              state_d      = S_FLUSH;
              pc_mux_sel_d = 1'b0;
              jmp_loc_d    = target_q;
              flush_d      = 1'b1;
              jump_count_d = jump_count_q + 8'd1;
            end else begin
              state_d = S_RUN;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d       = S_RUN;
            timeout_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            stall_d    = 1'b1;
          end
        end
        S_HALT: begin
          if (!resume) begin
            stall_d  = 1'b1;
            halted_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end

    stall_pm_d = stall_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= 4'd0;
      target_q      <= 8'd0;
      pc_mux_sel_q  <= 1'b1;
      jmp_loc_q     <= 8'd0;
      stall_q       <= 1'b0;
      stall_pm_q    <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      jump_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      target_q      <= target_d;
      pc_mux_sel_q  <= pc_mux_sel_d;
      jmp_loc_q     <= jmp_loc_d;
      stall_q       <= stall_d;
      stall_pm_q    <= stall_pm_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
      jump_count_q  <= jump_count_d;
    end
  end

  assign pc_mux_sel  = pc_mux_sel_q;
  assign jmp_loc     = jmp_loc_q;
  assign stall       = stall_q;
  assign stall_pm    = stall_pm_q;
  assign flush       = flush_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign jump_count  = jump_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: a per-cycle vector table plus hand-written
// sequences for counter wrap and asynchronous reset.
module tb_pc_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins;
  logic        zero_flag, flag_valid, ext_stall, resume;
  logic        pc_mux_sel, stall, stall_pm, flush, halted, timeout_err;
  logic [7:0]  jmp_loc, jump_count;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_flow_ctrl #(.FLAG_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ins         (ins),
    .zero_flag   (zero_flag),
    .flag_valid  (flag_valid),
    .ext_stall   (ext_stall),
    .resume      (resume),
    .pc_mux_sel  (pc_mux_sel),
    .jmp_loc     (jmp_loc),
    .stall       (stall),
    .stall_pm    (stall_pm),
    .flush       (flush),
    .halted      (halted),
    .timeout_err (timeout_err),
    .jump_count  (jump_count),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    string       name;
    logic [19:0] ins;
    logic        zf, fv, es, rs;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [21:0] RST_OUT = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [7:0] t);
    return {op, 7'b0, t};
  endfunction

  // Expected output bundle; stall_pm always mirrors stall.
  function automatic logic [21:0] pk(input logic pms, input logic [7:0] jl, input logic st,
                                     input logic fl, input logic hl, input logic to,
                                     input logic [7:0] jc);
    return {pms, jl, st, st, fl, hl, to, jc};
  endfunction

  function automatic logic [21:0] outs();
    return {pc_mux_sel, jmp_loc, stall, stall_pm, flush, halted, timeout_err, jump_count};
  endfunction

  task automatic add(input string n, input logic [19:0] i, input logic zf, input logic fv,
                     input logic es, input logic rs, input logic [21:0] e);
    vec_t v;
    v.name = n; v.ins = i; v.zf = zf; v.fv = fv; v.es = es; v.rs = rs; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h (pms,jl,st,stpm,fl,hl,to,jc)", n, act, exp);
    end
  endtask

  task automatic check8(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step(input logic [19:0] i, input logic zf, input logic fv,
                      input logic es, input logic rs);
    ins = i; zero_flag = zf; flag_valid = fv; ext_stall = es; resume = rs;
    @(posedge clk);
    #1;
  endtask

  logic [19:0] NOP, HLT;

  initial begin
    NOP = 20'h0;
    HLT = mk(5'b11111, 8'h00);

    // Sequential table: each entry is applied for one cycle, checked after the edge.
    add("nop0",        NOP,              0, 0, 0, 0, pk(1, 8'h00, 0, 0, 0, 0, 8'd0));
    add("nop1",        NOP,              0, 0, 0, 0, pk(1, 8'h00, 0, 0, 0, 0, 8'd0));
    add("jmp08",       mk(5'b11000, 8'h08), 0, 0, 0, 0, pk(0, 8'h08, 0, 1, 0, 0, 8'd1));
    add("jmp_squash",  mk(5'b11000, 8'h08), 0, 0, 0, 0, pk(1, 8'h08, 0, 0, 0, 0, 8'd1));
    add("nop_after",   NOP,              0, 0, 0, 0, pk(1, 8'h08, 0, 0, 0, 0, 8'd1));
    add("jz20",        mk(5'b11100, 8'h20), 0, 0, 0, 0, pk(1, 8'h08, 1, 0, 0, 0, 8'd1));
    add("jz20_w1",     NOP,              0, 0, 0, 0, pk(1, 8'h08, 1, 0, 0, 0, 8'd1));
    add("jz20_w2",     NOP,              0, 0, 0, 0, pk(1, 8'h08, 1, 0, 0, 0, 8'd1));
    add("jz20_taken",  NOP,              1, 1, 0, 0, pk(0, 8'h20, 0, 1, 0, 0, 8'd2));
    add("jz20_flushd", NOP,              0, 0, 0, 0, pk(1, 8'h20, 0, 0, 0, 0, 8'd2));
    add("jz30",        mk(5'b11100, 8'h30), 0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    add("jz30_w1",     NOP,              0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    add("jz30_w2",     NOP,              0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    add("jz30_ntaken", NOP,              0, 1, 0, 0, pk(1, 8'h20, 0, 0, 0, 0, 8'd2));
    add("jz40",        mk(5'b11100, 8'h40), 0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    for (int i = 0; i < 3; i++)
      add("jz40_wait", NOP,              0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    add("jz40_tmo",    NOP,              0, 0, 0, 0, pk(1, 8'h20, 0, 0, 0, 1, 8'd2));
    add("tmo_pulse",   NOP,              0, 0, 0, 0, pk(1, 8'h20, 0, 0, 0, 0, 8'd2));
    add("jz44",        mk(5'b11100, 8'h44), 0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    for (int i = 0; i < 3; i++)
      add("jz44_wait", NOP,              0, 0, 0, 0, pk(1, 8'h20, 1, 0, 0, 0, 8'd2));
    add("flag_wins",   NOP,              1, 1, 0, 0, pk(0, 8'h44, 0, 1, 0, 0, 8'd3));
    add("flag_wins_f", NOP,              0, 0, 0, 0, pk(1, 8'h44, 0, 0, 0, 0, 8'd3));
    add("hlt",         HLT,              0, 0, 0, 0, pk(1, 8'h44, 1, 0, 1, 0, 8'd3));
    for (int i = 0; i < 10; i++)
      add("hlt_hold",  (i == 4) ? mk(5'b11000, 8'h99) : NOP,
                                         0, 0, 0, 0, pk(1, 8'h44, 1, 0, 1, 0, 8'd3));
    add("resume",      NOP,              0, 0, 0, 1, pk(1, 8'h44, 0, 0, 0, 0, 8'd3));
    add("resume_run",  NOP,              0, 0, 0, 1, pk(1, 8'h44, 0, 0, 0, 0, 8'd3));
    add("jmp55",       mk(5'b11000, 8'h55), 0, 0, 0, 0, pk(0, 8'h55, 0, 1, 0, 0, 8'd4));
    for (int i = 0; i < 3; i++)
      add("es_flush",  NOP,              0, 0, 1, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("es_rel",      NOP,              0, 0, 0, 0, pk(1, 8'h55, 0, 0, 0, 0, 8'd4));
    add("es_rel_nop",  NOP,              0, 0, 0, 0, pk(1, 8'h55, 0, 0, 0, 0, 8'd4));
    add("es_blk_jmp",  mk(5'b11000, 8'h66), 0, 0, 1, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("es_blk_rel",  NOP,              0, 0, 0, 0, pk(1, 8'h55, 0, 0, 0, 0, 8'd4));
    add("jz70",        mk(5'b11100, 8'h70), 0, 0, 0, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("jz70_w1",     NOP,              0, 0, 0, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    for (int i = 0; i < 3; i++)
      add("es_wait",   NOP,              1, 1, 1, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("jz70_w2",     NOP,              0, 0, 0, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("jz70_w3",     NOP,              0, 0, 0, 0, pk(1, 8'h55, 1, 0, 0, 0, 8'd4));
    add("jz70_tmo",    NOP,              0, 0, 0, 0, pk(1, 8'h55, 0, 0, 0, 1, 8'd4));
    add("jz70_after",  NOP,              0, 0, 0, 0, pk(1, 8'h55, 0, 0, 0, 0, 8'd4));
    add("hlt2",        HLT,              0, 0, 0, 0, pk(1, 8'h55, 1, 0, 1, 0, 8'd4));
    add("hlt2_es",     NOP,              0, 0, 1, 0, pk(1, 8'h55, 1, 0, 1, 0, 8'd4));
    add("hlt2_es_rs",  NOP,              0, 0, 1, 1, pk(1, 8'h55, 1, 0, 1, 0, 8'd4));
    add("hlt2_hold",   NOP,              0, 0, 0, 0, pk(1, 8'h55, 1, 0, 1, 0, 8'd4));
    add("hlt2_resume", NOP,              0, 0, 0, 1, pk(1, 8'h55, 0, 0, 0, 0, 8'd4));

    // Reset held for two cycles with random instructions.
    reset = 1'b0; ins = 20'($urandom); zero_flag = 0; flag_valid = 0; ext_stall = 0; resume = 0;
    for (int i = 0; i < 2; i++) begin
      step(20'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom));
      check("reset_hold", outs(), RST_OUT);
    end
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ins, vecs[i].zf, vecs[i].fv, vecs[i].es, vecs[i].rs);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Jump-count wrap: a steady JMP redirects every other cycle.
    reset = 1'b0;
    #1;
    check("wrap_reset", outs(), RST_OUT);
    reset = 1'b1;
    for (int i = 0; i < 509; i++) step(mk(5'b11000, 8'hA5), 0, 0, 0, 0);
    check("wrap_255", outs(), pk(0, 8'hA5, 0, 1, 0, 0, 8'd255));
    step(mk(5'b11000, 8'hA5), 0, 0, 0, 0);
    check8("wrap_squash_jc", jump_count, 8'd255);
    step(mk(5'b11000, 8'hA5), 0, 0, 0, 0);
    check("wrap_0", outs(), pk(0, 8'hA5, 0, 1, 0, 0, 8'd0));
    step(NOP, 0, 0, 0, 0);
    check("wrap_done", outs(), pk(1, 8'hA5, 0, 0, 0, 0, 8'd0));

    // Asynchronous reset in the middle of a flag wait.
    step(mk(5'b11100, 8'hC3), 0, 0, 0, 0);
    step(NOP, 0, 0, 0, 0);
    check("areset_pre", outs(), pk(1, 8'hA5, 1, 0, 0, 0, 8'd0));
    #2 reset = 1'b0;
    #1;
    check("areset_now", outs(), RST_OUT);
    check8("areset_state", {6'd0, state_dbg}, 8'd0);
    #3 reset = 1'b1;
    step(NOP, 1, 1, 0, 0);
    check("areset_after", outs(), RST_OUT);
    step(NOP, 0, 0, 0, 0);
    check("areset_after2", outs(), RST_OUT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
Control sequencer for the Program_Counter / program-memory fetch path. It decodes the instruction in the decode stage and resolves jumps, conditional jumps and halts. It drives the PC mux select, jump target, PC and program-memory stall lines, and a pipeline flush strobe. It also keeps a taken-jump counter for debug.

Parameters:
OPC_JMP, 5'b11000, opcode of unconditional jump
OPC_JZ, 5'b11100, opcode of jump-if-zero
OPC_HLT, 5'b11111, opcode of halt
FLAG_TIMEOUT, 4, max cycles to wait for flag_valid in WAIT_FLAG (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ins  in  20  decode-stage instruction; opcode = ins[19:15], target = ins[7:0]
zero_flag  in  1  zero flag from execute stage
flag_valid  in  1  zero_flag is valid this cycle
ext_stall  in  1  external stall request (memory/peripheral)
resume  in  1  single-cycle pulse; leaves HALT
pc_mux_sel  out  1  1 = PC increments, 0 = PC loads jmp_loc
jmp_loc  out  8  jump target address
stall  out  1  holds the PC
stall_pm  out  1  holds the program-memory output register
flush  out  1  squashes the fetched instruction (1 cycle)
halted  out  1  core halted
timeout_err  out  1  1-cycle pulse on flag-wait timeout
jump_count  out  8  count of taken jumps, wraps

Behaviour:
- All outputs are registered. Asynchronous reset (reset=0) forces: state=RUN, pc_mux_sel=1, jmp_loc=0, stall=0, stall_pm=0, flush=0, halted=0, timeout_err=0, jump_count=0, wait counter=0.
- Reset asserted mid-operation aborts any jump, wait or halt immediately. There is no residual flush after reset.
- Priority: reset > ext_stall > FSM.
- ext_stall=1 behaviour:
  - stall=stall_pm=1 in the same registered cycle.
  - FSM state, wait counter, jmp_loc and jump_count are frozen.
  - pc_mux_sel and flush are forced to 1 and 0.
  - A pending FLUSH resumes after ext_stall drops.
- States:
  - RUN:
    - opcode==OPC_JMP → FLUSH. At the next edge: pc_mux_sel=0, jmp_loc=ins[7:0], flush=1, jump_count+1.
    - opcode==OPC_JZ → WAIT_FLAG. At the next edge: stall=stall_pm=1, latch target=ins[7:0], wait counter=0.
    - opcode==OPC_HLT → HALT. At the next edge: stall=stall_pm=1, halted=1.
    - Otherwise: pc_mux_sel=1, stall=stall_pm=0, flush=0.
  - FLUSH (exactly 1 cycle):
    - ins is ignored (squashed slot).
    - Next edge: pc_mux_sel=1, flush=0 → RUN.
  - WAIT_FLAG:
    - stall=stall_pm=1 held.
    - flag_valid=1 and zero_flag=1 → taken. Behaves as JMP: → FLUSH, stall=0, pc_mux_sel=0, jmp_loc=target, flush=1, jump_count+1.
    - flag_valid=1 and zero_flag=0 → not taken: → RUN, stall=stall_pm=0.
    - flag_valid=0 → wait counter+1. When the counter reaches FLAG_TIMEOUT-1 without a valid flag: treat as not taken, → RUN, timeout_err=1 for 1 cycle.
    - flag_valid on the same cycle as the timeout: flag wins.
  - HALT:
    - stall=stall_pm=1, halted=1, ins ignored.
    - resume=1 → RUN: stall=0, halted=0.
    - resume outside HALT is ignored.
- jump_count: 8-bit unsigned, 255+1 → 0, no saturation.
- jmp_loc holds its last value when pc_mux_sel=1.
- Latency: decode of jump → PC redirect at +1 edge; one squashed slot.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with random ins → all outputs at reset values. Release, drive NOP (5'b00000) → pc_mux_sel=1, stall=0 each cycle.
2. JMP: ins={5'b11000,7'b0,8'h08} for 1 cycle → next cycle pc_mux_sel=0, jmp_loc=8'h08, flush=1, jump_count=1. The following cycle has pc_mux_sel=1, flush=0, and the JMP re-presented in the squashed slot is ignored.
3. JZ taken / not taken:
   - JZ target 8'h20, flag_valid=1 after 2 cycles with zero_flag=1 → stall=1 for 3 cycles, then pc_mux_sel=0, jmp_loc=8'h20, flush=1.
   - Repeat with zero_flag=0 → stall drops, pc_mux_sel stays 1, jump_count unchanged.
4. JZ timeout: JZ with flag_valid held 0 → stall=1 for FLAG_TIMEOUT=4 cycles, then timeout_err=1 for 1 cycle, stall=0, no jump.
5. HLT and ext_stall:
   - HLT → halted=1, stall=stall_pm=1 held 10 cycles; resume pulse → halted=0, stall=0 next cycle.
   - ext_stall=1 for 3 cycles during FLUSH → stall=1, flush=0 while held. FLUSH completes after release; jump_count incremented once.
6. Wrap and async reset:
   - 256 JMPs → jump_count returns to 0.
   - reset=0 asynchronously mid-WAIT_FLAG → outputs clear before the next clock edge.
